// File: rtl/microwave_timer_ctrl.sv
// Microwave MM:SS cook-timer sequencer: keypad entry, cascade load, cook/pause, expiry beep.
// Latency: state and all outputs except cnt_en are registered (1 clk); cnt_en is combinational.
// Backpressure: none; inputs are sampled every clk, with clear > stop/door > start > key.
module microwave_timer_ctrl #(
    parameter int BEEP_TICKS = 3,
    parameter int TICK_W     = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       tick,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       door_closed,
    input  logic       time_zero,
    output logic       cnt_loadn,
    output logic [3:0] cnt_data_m,
    output logic [3:0] cnt_data_st,
    output logic [3:0] cnt_data_so,
    output logic       cnt_en,
    output logic       mag_on,
    output logic       beep,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTRY = 3'd1,
        S_LOAD  = 3'd2,
        S_COOK  = 3'd3,
        S_PAUSE = 3'd4,
        S_DONE  = 3'd5,
        S_ZERO  = 3'd6
    } state_t;

    // Tick count at which the beep phase ends.
    localparam logic [TICK_W-1:0] BEEP_LAST = TICK_W'(BEEP_TICKS - 1);

    state_t            state_q, state_d;
    logic [3:0]        m_q, m_d;
    logic [3:0]        st_q, st_d;
    logic [3:0]        so_q, so_d;
    logic [TICK_W-1:0] beep_cnt_q, beep_cnt_d;
    logic              cnt_loadn_q, cnt_loadn_d;
    logic [3:0]        cnt_data_m_q, cnt_data_m_d;
    logic [3:0]        cnt_data_st_q, cnt_data_st_d;
    logic [3:0]        cnt_data_so_q, cnt_data_so_d;
    logic              mag_on_q, mag_on_d;
    logic              beep_q, beep_d;

    logic              hold;
    logic              key_ok;
    logic              entry_nz;

    // Request qualifiers shared by several states.
    assign hold     = stop | ~door_closed;
    // A key is only taken while the seconds-ones digit could legally become seconds-tens.
    assign key_ok   = key_valid && (key_digit <= 4'd9) && (so_q <= 4'd5);
    assign entry_nz = |{m_q, st_q, so_q};

    // Next-state, entry register and registered-output computation.
    always_comb begin
        state_d    = state_q;
        m_d        = m_q;
        st_d       = st_q;
        so_d       = so_q;
        beep_cnt_d = beep_cnt_q;

        case (state_q)
            S_IDLE, S_ENTRY: begin
                if (clear) begin
                    state_d = S_ZERO;
                    m_d     = 4'd0;
                    st_d    = 4'd0;
                    so_d    = 4'd0;
                end else if (hold) begin
                    // Stop or open door pre-empts both start and keypad this cycle.
                    state_d = state_q;
                end else if (start && (state_q == S_ENTRY) && entry_nz) begin
                    state_d = S_LOAD;
                end else if (key_ok) begin
                    m_d     = st_q;
                    st_d    = so_q;
                    so_d    = key_digit;
                    state_d = S_ENTRY;
                end
            end

            S_LOAD: begin
                state_d = S_COOK;
            end

            S_COOK: begin
                if (clear) begin
                    state_d = S_ZERO;
                    m_d     = 4'd0;
                    st_d    = 4'd0;
                    so_d    = 4'd0;
                end else if (time_zero) begin
                    // Expiry beats a simultaneous stop or door open.
                    state_d = S_DONE;
                end else if (hold) begin
                    state_d = S_PAUSE;
                end
            end

            S_PAUSE: begin
                if (clear) begin
                    state_d = S_ZERO;
                    m_d     = 4'd0;
                    st_d    = 4'd0;
                    so_d    = 4'd0;
                end else if (!hold && start) begin
                    // Resume from wherever the cascade stopped; no reload.
                    state_d = S_COOK;
                end
            end

            S_DONE: begin
                if (clear || key_valid) begin
                    state_d = S_IDLE;
                    m_d     = 4'd0;
                    st_d    = 4'd0;
                    so_d    = 4'd0;
                end else if (tick) begin
                    if (beep_cnt_q == BEEP_LAST) begin
                        state_d = S_IDLE;
                        m_d     = 4'd0;
                        st_d    = 4'd0;
                        so_d    = 4'd0;
                    end else begin
                        beep_cnt_d = beep_cnt_q + 1'b1;
                    end
                end
            end

            S_ZERO: begin
                state_d = S_IDLE;
                m_d     = 4'd0;
                st_d    = 4'd0;
                so_d    = 4'd0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The beep counter only lives while in DONE; it restarts on every entry.
        if (state_d != S_DONE) begin
            beep_cnt_d = '0;
        end

        // Outputs are decodes of the next state, registered alongside it.
        cnt_loadn_d   = !((state_d == S_LOAD) || (state_d == S_ZERO));
        cnt_data_m_d  = (state_d == S_ZERO) ? 4'd0 : m_d;
        cnt_data_st_d = (state_d == S_ZERO) ? 4'd0 : st_d;
        cnt_data_so_d = (state_d == S_ZERO) ? 4'd0 : so_d;
        mag_on_d      = (state_d == S_COOK);
        beep_d        = (state_d == S_DONE);
    end

    // State, entry registers and registered outputs, with synchronous reset.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q       <= S_IDLE;
            m_q           <= 4'd0;
            st_q          <= 4'd0;
            so_q          <= 4'd0;
            beep_cnt_q    <= '0;
            cnt_loadn_q   <= 1'b1;
            cnt_data_m_q  <= 4'd0;
            cnt_data_st_q <= 4'd0;
            cnt_data_so_q <= 4'd0;
            mag_on_q      <= 1'b0;
            beep_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            m_q           <= m_d;
            st_q          <= st_d;
            so_q          <= so_d;
            beep_cnt_q    <= beep_cnt_d;
            cnt_loadn_q   <= cnt_loadn_d;
            cnt_data_m_q  <= cnt_data_m_d;
            cnt_data_st_q <= cnt_data_st_d;
            cnt_data_so_q <= cnt_data_so_d;
            mag_on_q      <= mag_on_d;
            beep_q        <= beep_d;
        end
    end

    // Count enable must never fire at zero, otherwise the cascade would wrap to 9.
    assign cnt_en      = (state_q == S_COOK) & tick & ~time_zero;

    assign cnt_loadn   = cnt_loadn_q;
    assign cnt_data_m  = cnt_data_m_q;
    assign cnt_data_st = cnt_data_st_q;
    assign cnt_data_so = cnt_data_so_q;
    assign mag_on      = mag_on_q;
    assign beep        = beep_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Directed bench for microwave_timer_ctrl with a small BCD cascade plant model.
// Inputs change 1 ns after the rising edge; outputs are checked there too.
// The plant counts down only on DUT load/enable and feeds time_zero back.
module tb_microwave_timer_ctrl;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       tick = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic       door_closed = 1'b1;
    logic       time_zero;
    logic       cnt_loadn;
    logic [3:0] cnt_data_m;
    logic [3:0] cnt_data_st;
    logic [3:0] cnt_data_so;
    logic       cnt_en;
    logic       mag_on;
    logic       beep;
    logic [2:0] state_o;

    // Cascade plant: minute ones, seconds tens (0..5), seconds ones.
    logic [3:0] cm = 4'd0;
    logic [3:0] cst = 4'd0;
    logic [3:0] cso = 4'd0;
    logic       tz_force = 1'b0;

    int total = 0;
    int bad = 0;

    microwave_timer_ctrl #(
        .BEEP_TICKS(3),
        .TICK_W(4)
    ) dut (
        .clk(clk),
        .clr(clr),
        .tick(tick),
        .key_valid(key_valid),
        .key_digit(key_digit),
        .start(start),
        .stop(stop),
        .clear(clear),
        .door_closed(door_closed),
        .time_zero(time_zero),
        .cnt_loadn(cnt_loadn),
        .cnt_data_m(cnt_data_m),
        .cnt_data_st(cnt_data_st),
        .cnt_data_so(cnt_data_so),
        .cnt_en(cnt_en),
        .mag_on(mag_on),
        .beep(beep),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    assign time_zero = tz_force | ((cm == 4'd0) && (cst == 4'd0) && (cso == 4'd0));

    always @(posedge clk) begin
        if (!cnt_loadn) begin
            cm  <= cnt_data_m;
            cst <= cnt_data_st;
            cso <= cnt_data_so;
        end else if (cnt_en) begin
            if (cso == 4'd0) begin
                cso <= 4'd9;
                if (cst == 4'd0) begin
                    cst <= 4'd5;
                    cm  <= (cm == 4'd0) ? 4'd9 : cm - 4'd1;
                end else begin
                    cst <= cst - 4'd1;
                end
            end else begin
                cso <= cso - 4'd1;
            end
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        step();
        key_valid = 1'b0;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        // Reset
        step(2);
        clr = 1'b0;
        chk("rst_state", 8'(state_o), 8'd0);
        chk("rst_loadn", 8'(cnt_loadn), 8'd1);
        chk("rst_en", 8'(cnt_en), 8'd0);
        chk("rst_mag", 8'(mag_on), 8'd0);
        chk("rst_beep", 8'(beep), 8'd0);
        chk("rst_data", {cnt_data_st, cnt_data_so}, 8'h00);

        // 1: keys 1,3,0 then start -> load 1:30, cook, cnt_en follows tick
        press(4'd1);
        chk("k1_state", 8'(state_o), 8'd1);
        chk("k1_so", 8'(cnt_data_so), 8'd1);
        press(4'd3);
        press(4'd0);
        chk("k130_m", 8'(cnt_data_m), 8'd1);
        chk("k130_st_so", {cnt_data_st, cnt_data_so}, 8'h30);
        pulse_start();
        chk("load_state", 8'(state_o), 8'd2);
        chk("load_loadn", 8'(cnt_loadn), 8'd0);
        chk("load_data", {cnt_data_m, cnt_data_st}, 8'h13);
        chk("load_mag", 8'(mag_on), 8'd0);
        step();
        chk("cook_state", 8'(state_o), 8'd3);
        chk("cook_loadn", 8'(cnt_loadn), 8'd1);
        chk("cook_mag", 8'(mag_on), 8'd1);
        chk("cook_plant", {cst, cso}, 8'h30);
        chk("cook_en_idle", 8'(cnt_en), 8'd0);
        tick = 1'b1;
        #1;
        chk("cook_en_tick", 8'(cnt_en), 8'd1);
        step();
        tick = 1'b0;
        #1;
        chk("cook_en_off", 8'(cnt_en), 8'd0);
        chk("cook_129", {cm, cst}, 8'h12);
        chk("cook_129_so", 8'(cso), 8'd9);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_zero", 8'(state_o), 8'd6);
        chk("clr_zero_loadn", 8'(cnt_loadn), 8'd0);
        chk("clr_zero_data", {cnt_data_m, cnt_data_so}, 8'h00);
        step();
        chk("clr_idle", 8'(state_o), 8'd0);

        // 2: 0:05 runs to zero, beep for 3 ticks, back to idle with entry cleared
        press(4'd5);
        pulse_start();
        step();
        chk("t2_cook", 8'(state_o), 8'd3);
        for (int i = 0; i < 4; i++) pulse_tick();
        chk("t2_4ticks_so", 8'(cso), 8'd1);
        chk("t2_4ticks_state", 8'(state_o), 8'd3);
        pulse_tick();
        chk("t2_zero_tz", 8'(time_zero), 8'd1);
        tick = 1'b1;
        #1;
        chk("t2_no_en_at_zero", 8'(cnt_en), 8'd0);
        step();
        tick = 1'b0;
        chk("t2_done", 8'(state_o), 8'd5);
        chk("t2_beep", 8'(beep), 8'd1);
        chk("t2_mag_off", 8'(mag_on), 8'd0);
        chk("t2_no_wrap", 8'(cso), 8'd0);
        step(3);
        chk("t2_done_hold", 8'(state_o), 8'd5);
        pulse_tick();
        pulse_tick();
        chk("t2_beep_2", 8'(beep), 8'd1);
        pulse_tick();
        chk("t2_idle", 8'(state_o), 8'd0);
        chk("t2_beep_off", 8'(beep), 8'd0);
        chk("t2_entry0", 8'(cnt_data_so), 8'd0);

        // 3: door opens at 0:42 -> pause; close+start resumes without reload
        press(4'd4);
        press(4'd2);
        pulse_start();
        step();
        chk("t3_cook", 8'(state_o), 8'd3);
        chk("t3_plant", {cst, cso}, 8'h42);
        door_closed = 1'b0;
        step();
        chk("t3_pause", 8'(state_o), 8'd4);
        chk("t3_mag_off", 8'(mag_on), 8'd0);
        tick = 1'b1;
        #1;
        chk("t3_en_pause", 8'(cnt_en), 8'd0);
        step();
        tick = 1'b0;
        door_closed = 1'b1;
        step();
        chk("t3_wait_start", 8'(state_o), 8'd4);
        pulse_start();
        chk("t3_resume", 8'(state_o), 8'd3);
        chk("t3_no_load", 8'(cnt_loadn), 8'd1);
        chk("t3_mag_on", 8'(mag_on), 8'd1);
        step();
        chk("t3_kept", {cst, cso}, 8'h42);
        pulse_tick();
        chk("t3_041", {cst, cso}, 8'h41);

        // 5a: clear + stop + time_zero in COOK -> ZERO then IDLE
        clear = 1'b1;
        stop = 1'b1;
        tz_force = 1'b1;
        step();
        clear = 1'b0;
        stop = 1'b0;
        tz_force = 1'b0;
        chk("t5_zero", 8'(state_o), 8'd6);
        chk("t5_zero_loadn", 8'(cnt_loadn), 8'd0);
        chk("t5_zero_data", {cnt_data_st, cnt_data_so}, 8'h00);
        step();
        chk("t5_idle", 8'(state_o), 8'd0);

        // 5b: time_zero together with door open -> DONE
        press(4'd9);
        pulse_start();
        step();
        chk("t5b_cook", 8'(state_o), 8'd3);
        door_closed = 1'b0;
        tz_force = 1'b1;
        step();
        door_closed = 1'b1;
        tz_force = 1'b0;
        chk("t5b_done", 8'(state_o), 8'd5);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("t5b_clr_idle", 8'(state_o), 8'd0);
        chk("t5b_beep_off", 8'(beep), 8'd0);

        // 4: key filtering and zero-entry start
        pulse_start();
        chk("t4_start_idle", 8'(state_o), 8'd0);
        press(4'd7);
        press(4'd8);
        chk("t4_78_so", 8'(cnt_data_so), 8'd7);
        chk("t4_78_st", 8'(cnt_data_st), 8'd0);
        clear = 1'b1;
        step(2);
        clear = 1'b0;
        chk("t4_cleared", 8'(state_o), 8'd0);
        press(4'hC);
        chk("t4_keyC_state", 8'(state_o), 8'd0);
        chk("t4_keyC_so", 8'(cnt_data_so), 8'd0);
        press(4'd0);
        chk("t4_key0_entry", 8'(state_o), 8'd1);
        pulse_start();
        chk("t4_zero_start", 8'(state_o), 8'd1);
        chk("t4_zero_loadn", 8'(cnt_loadn), 8'd1);

        // 6: clr during COOK, with a simultaneous key
        press(4'd1);
        pulse_start();
        step();
        chk("t6_cook", 8'(state_o), 8'd3);
        clr = 1'b1;
        key_valid = 1'b1;
        key_digit = 4'd5;
        step();
        clr = 1'b0;
        key_valid = 1'b0;
        chk("t6_state", 8'(state_o), 8'd0);
        chk("t6_mag", 8'(mag_on), 8'd0);
        chk("t6_loadn", 8'(cnt_loadn), 8'd1);
        chk("t6_entry", 8'(cnt_data_so), 8'd0);
        step();
        chk("t6_idle_hold", 8'(state_o), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/microwave_timer_ctrl.md
Name: microwave_timer_ctrl

Overview:
Sequencer for the MM:SS cook timer, a three-digit cascade of BCD down-counters with active-low load and enable (minute ones, seconds tens, seconds ones).
- Captures keypad digits into an entry register and loads the cascade.
- Gates the 1 Hz tick into the seconds-ones counter enable.
- Drives the magnetron enable and handles door, stop, start and clear.
- Detects expiry and generates a timed beep before returning to idle.

Parameters:
BEEP_TICKS, 3, number of tick pulses beep stays high in DONE (1..15)
TICK_W, 4, width of internal beep tick counter

Ports:
clk  input  1  system clock, all logic on rising edge
clr  input  1  synchronous active-high reset
tick  input  1  1 Hz enable pulse, one clk wide
key_valid  input  1  keypad strobe, one clk wide
key_digit  input  4  keypad value; only 0..9 meaningful
start  input  1  start/resume request, level sampled each clk
stop  input  1  pause request
clear  input  1  abort/clear request
door_closed  input  1  1 = door closed
time_zero  input  1  AND of the cascade's zero flags
cnt_loadn  output  1  active-low load to all three counters
cnt_data_m  output  4  load value, minute ones
cnt_data_st  output  4  load value, seconds tens
cnt_data_so  output  4  load value, seconds ones
cnt_en  output  1  enable to the seconds-ones counter (the cascade ripples via tc)
mag_on  output  1  magnetron enable
beep  output  1  expiry beeper
state_o  output  3  current state encoding, for display/debug

Behaviour:
- Reset (clr=1 at a clk edge) forces the following, overriding all inputs:
  - state = IDLE; entry registers m/st/so = 0; beep counter = 0.
  - Outputs: cnt_loadn=1, cnt_en=0, mag_on=0, beep=0.
- States and encodings: IDLE=0, ENTRY=1, LOAD=2, COOK=3, PAUSE=4, DONE=5, ZERO=6. Code 7 is illegal and recovers to IDLE next cycle.
- Input priority within a cycle: clear > (stop or !door_closed) > start > key_valid.
- Key accept, IDLE/ENTRY only:
  - Condition: key_digit<=9 and current so<=5.
  - Shift-left: m<=st, st<=so, so<=key_digit.
  - Otherwise the key is ignored and no state change occurs. Keys in any other state are ignored.
  - An accepted key in IDLE moves to ENTRY.
- ENTRY:
  - clear -> ZERO.
  - start & door_closed & (m|st|so != 0) -> LOAD.
  - start with door open or all-zero entry is ignored.
- LOAD: exactly one cycle.
  - cnt_loadn=0; cnt_data_* = entry registers; cnt_en=0.
  - Next state COOK unconditionally.
- COOK:
  - mag_on=1; cnt_en = tick & !time_zero (never enable at zero, which prevents wrap to 9).
  - time_zero=1 -> DONE. This takes precedence over stop/door in the same cycle, but clear still wins.
  - clear -> ZERO; stop or !door_closed -> PAUSE.
- PAUSE:
  - mag_on=0, cnt_en=0.
  - start & door_closed -> COOK, with no reload.
  - clear -> ZERO.
- DONE:
  - mag_on=0; beep=1.
  - The beep counter increments on tick. After BEEP_TICKS ticks -> IDLE with the entry cleared.
  - clear or key_valid -> IDLE immediately; the key is not captured.
- ZERO: one cycle.
  - cnt_loadn=0 with cnt_data_* = 0; entry registers cleared.
  - Next state IDLE.
- cnt_data_* show the entry registers in all states except ZERO, where they are 0.
- All outputs except cnt_en are Moore decodes of state; cnt_en is state&tick&!time_zero, combinational.
- Latencies:
  - start in ENTRY -> load pulse the next cycle -> mag_on the cycle after.
  - The door opening drops mag_on one clk after it is sampled.

Test Plan:
1. Keys 1,3,0 then start, door closed -> entry m=1 st=3 so=0; one cnt_loadn=0 cycle with data 1/3/0; COOK with mag_on=1; cnt_en pulses track tick.
2. Model cascade; entry 0:05; run -> after 5 ticks time_zero=1; DONE with beep=1 for exactly 3 ticks; no cnt_en at zero; IDLE, entry 0.
3. Door opens mid-cook at 0:42 -> PAUSE, mag_on=0 next clk, cnt_en=0; close and start -> COOK resumes from 0:42 with no load pulse.
4. Key 7 then key 8 -> 78 rejected for the tens digit, so entry stays so=7; key 0xC ignored; start with entry 0:00 stays in IDLE/ENTRY.
5. Same cycle: clear, stop and time_zero in COOK -> ZERO (zero load pulse) then IDLE; separately, time_zero together with door open -> DONE.
6. clr asserted in COOK -> next clk IDLE, mag_on=0, cnt_loadn=1, entry 0; key_valid in the same cycle as clr is ignored.
